// File: rtl/dht11_frame_formatter.sv
// ============================================================================
// dht11_frame_formatter: assembles a 40-bit DHT11 frame, verifies its checksum
// and emits "H=ddd T=ddd\r\n" (or "ERR\r\n") one character at a time to a UART.
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module dht11_frame_formatter #(
    parameter logic SEND_ERR = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_start,
    input  logic       bit_valid,
    input  logic       bit_val,
    input  logic       tx_busy,
    output logic [7:0] tx_data,
    output logic       tx_send,
    output logic       busy,
    output logic       csum_err,
    output logic [7:0] good_count
);

    typedef enum logic [2:0] {
        S_COLLECT = 3'd0,
        S_CHECK   = 3'd1,
        S_CONVERT = 3'd2,
        S_LOAD    = 3'd3,
        S_SEND    = 3'd4,
        S_WAIT_HI = 3'd5,
        S_WAIT_LO = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic [39:0] shift_q, shift_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  conv_cnt_q, conv_cnt_d;
    logic [19:0] dd_q, dd_d;
    logic [11:0] h_bcd_q, h_bcd_d;
    logic [11:0] t_bcd_q, t_bcd_d;
    logic        err_msg_q, err_msg_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_send_q, tx_send_d;
    logic        csum_err_q, csum_err_d;
    logic [7:0]  good_count_q, good_count_d;

    logic [7:0]  csum_calc;
    logic [19:0] dd_next;
    logic [7:0]  cur_char;
    logic [3:0]  last_idx;

    // One double-dabble iteration: BCD digits live in [19:8], binary in [7:0].
    function automatic logic [19:0] dd_step(input logic [19:0] v);
        logic [19:0] a;
        a = v;
        for (int i = 0; i < 3; i++) begin
            if (a[8+4*i +: 4] >= 4'd5) begin
                a[8+4*i +: 4] = a[8+4*i +: 4] + 4'd3;
            end
        end
        return a << 1;
    endfunction

    function automatic logic [7:0] msg_char(input logic err, input logic [3:0] idx,
                                            input logic [11:0] h, input logic [11:0] t);
        logic [7:0] c;
        c = 8'h00;
        if (err) begin
            case (idx)
                4'd0, 4'd1: c = (idx == 4'd0) ? 8'h45 : 8'h52;
                4'd2:       c = 8'h52;
                4'd3:       c = 8'h0D;
                default:    c = 8'h0A;
            endcase
        end else begin
            case (idx)
                4'd0:    c = 8'h48;
                4'd1:    c = 8'h3D;
                4'd2:    c = 8'h30 + {4'd0, h[11:8]};
                4'd3:    c = 8'h30 + {4'd0, h[7:4]};
                4'd4:    c = 8'h30 + {4'd0, h[3:0]};
                4'd5:    c = 8'h20;
                4'd6:    c = 8'h54;
                4'd7:    c = 8'h3D;
                4'd8:    c = 8'h30 + {4'd0, t[11:8]};
                4'd9:    c = 8'h30 + {4'd0, t[7:4]};
                4'd10:   c = 8'h30 + {4'd0, t[3:0]};
                4'd11:   c = 8'h0D;
                default: c = 8'h0A;
            endcase
        end
        return c;
    endfunction

    assign csum_calc = shift_q[39:32] + shift_q[31:24] + shift_q[23:16] + shift_q[15:8];
    assign dd_next   = dd_step(dd_q);
    assign cur_char  = msg_char(err_msg_q, idx_q, h_bcd_q, t_bcd_q);
    assign last_idx  = err_msg_q ? 4'd4 : 4'd12;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        idx_d        = idx_q;
        conv_cnt_d   = conv_cnt_q;
        dd_d         = dd_q;
        h_bcd_d      = h_bcd_q;
        t_bcd_d      = t_bcd_q;
        err_msg_d    = err_msg_q;
        tx_data_d    = tx_data_q;
        tx_send_d    = 1'b0;
        csum_err_d   = csum_err_q;
        good_count_d = good_count_q;

        case (state_q)
            S_COLLECT: begin
                // A bit arriving with frame_start lands as bit 0 of the new frame.
                if (frame_start) begin
                    bit_cnt_d  = 6'd0;
                    shift_d    = 40'd0;
                    csum_err_d = 1'b0;
                end
                if (bit_valid) begin
                    shift_d   = {shift_d[38:0], bit_val};
                    bit_cnt_d = bit_cnt_d + 6'd1;
                    if (bit_cnt_d == 6'd40) begin
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (csum_calc == shift_q[7:0]) begin
                    csum_err_d   = 1'b0;
                    good_count_d = good_count_q + 8'd1;
                    dd_d         = {12'd0, shift_q[39:32]};
                    conv_cnt_d   = 4'd0;
                    err_msg_d    = 1'b0;
                    state_d      = S_CONVERT;
                end else begin
                    csum_err_d = 1'b1;
                    if (SEND_ERR) begin
                        err_msg_d = 1'b1;
                        idx_d     = 4'd0;
                        state_d   = S_LOAD;
                    end else begin
                        bit_cnt_d = 6'd0;
                        state_d   = S_COLLECT;
                    end
                end
            end
            S_CONVERT: begin
                // Cycles 0-7 convert humidity, 8-15 temperature.
                dd_d       = dd_next;
                conv_cnt_d = conv_cnt_q + 4'd1;
                if (conv_cnt_q == 4'd7) begin
                    h_bcd_d = dd_next[19:8];
                    dd_d    = {12'd0, shift_q[23:16]};
                end
                if (conv_cnt_q == 4'd15) begin
                    t_bcd_d = dd_next[19:8];
                    idx_d   = 4'd0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                tx_data_d = cur_char;
                state_d   = S_SEND;
            end
            S_SEND: begin
                if (!tx_busy) begin
                    tx_send_d = 1'b1;
                    state_d   = S_WAIT_HI;
                end
            end
            S_WAIT_HI: begin
                if (tx_busy) begin
                    state_d = S_WAIT_LO;
                end
            end
            S_WAIT_LO: begin
                if (!tx_busy) begin
                    if (idx_q == last_idx) begin
                        idx_d     = 4'd0;
                        bit_cnt_d = 6'd0;
                        state_d   = S_COLLECT;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = S_LOAD;
                    end
                end
            end
            default: state_d = S_COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_COLLECT;
            bit_cnt_q    <= 6'd0;
            shift_q      <= 40'd0;
            idx_q        <= 4'd0;
            conv_cnt_q   <= 4'd0;
            dd_q         <= 20'd0;
            h_bcd_q      <= 12'd0;
            t_bcd_q      <= 12'd0;
            err_msg_q    <= 1'b0;
            tx_data_q    <= 8'h00;
            tx_send_q    <= 1'b0;
            csum_err_q   <= 1'b0;
            good_count_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            idx_q        <= idx_d;
            conv_cnt_q   <= conv_cnt_d;
            dd_q         <= dd_d;
            h_bcd_q      <= h_bcd_d;
            t_bcd_q      <= t_bcd_d;
            err_msg_q    <= err_msg_d;
            tx_data_q    <= tx_data_d;
            tx_send_q    <= tx_send_d;
            csum_err_q   <= csum_err_d;
            good_count_q <= good_count_d;
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_send    = tx_send_q;
    assign busy       = (state_q != S_COLLECT);
    assign csum_err   = csum_err_q;
    assign good_count = good_count_q;

endmodule

`default_nettype wire

// File: tb/tb_dht11_frame_formatter.sv
// ============================================================================
// tb_dht11_frame_formatter: scoreboard bench for dht11_frame_formatter,
// one instance with SEND_ERR=1 and one with SEND_ERR=0 sharing the sensor inputs.
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_dht11_frame_formatter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       frame_start = 1'b0;
    logic       bit_valid = 1'b0;
    logic       bit_val = 1'b0;
    logic       tx_busy1 = 1'b0;
    logic       tx_busy2 = 1'b0;
    logic [7:0] tx_data1, tx_data2, gc1, gc2;
    logic       tx_send1, tx_send2, busy1, busy2, cerr1, cerr2;

    int n_checks = 0;
    int n_pass = 0;
    int hold = 1;
    int u1_cnt = 0;
    int u2_cnt = 0;
    int tx1_count = 0;
    int tx2_count = 0;
    int exp2_count = 0;
    int model_gc = 0;
    int good_total = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;
    logic prev1 = 1'b0;
    logic prev2 = 1'b0;

    always #5 clk = ~clk;

    dht11_frame_formatter #(.SEND_ERR(1'b1)) u_dut_err (
        .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .bit_valid(bit_valid),
        .bit_val(bit_val), .tx_busy(tx_busy1), .tx_data(tx_data1), .tx_send(tx_send1),
        .busy(busy1), .csum_err(cerr1), .good_count(gc1)
    );

    dht11_frame_formatter #(.SEND_ERR(1'b0)) u_dut_drop (
        .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .bit_valid(bit_valid),
        .bit_val(bit_val), .tx_busy(tx_busy2), .tx_data(tx_data2), .tx_send(tx_send2),
        .busy(busy2), .csum_err(cerr2), .good_count(gc2)
    );

    // UART models: busy rises the cycle after a send and holds for `hold` cycles.
    always @(posedge clk) begin
        if (u1_cnt != 0) begin
            u1_cnt <= u1_cnt - 1;
            if (u1_cnt == 1) tx_busy1 <= 1'b0;
        end else if (tx_send1) begin
            tx_busy1 <= 1'b1;
            u1_cnt   <= hold;
        end
        if (u2_cnt != 0) begin
            u2_cnt <= u2_cnt - 1;
            if (u2_cnt == 1) tx_busy2 <= 1'b0;
        end else if (tx_send2) begin
            tx_busy2 <= 1'b1;
            u2_cnt   <= hold;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    // Monitor: every send strobe pops the next expected character.
    always @(negedge clk) begin
        if (tx_send1) begin
            tx1_count++;
            check("send1_not_back_to_back", int'(prev1), 0);
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL tx_char: unexpected tx_send with data 0x%02h, none expected", tx_data1);
            end else begin
                mon_exp = exp_q.pop_front();
                check("tx_char", int'(tx_data1), int'(mon_exp));
            end
        end
        prev1 = tx_send1;
        if (tx_send2) begin
            tx2_count++;
            check("send2_not_back_to_back", int'(prev2), 0);
        end
        prev2 = tx_send2;
    end

    task automatic push_expected(input logic [7:0] h, input logic [7:0] t, input bit good);
        if (good) begin
            exp_q.push_back(8'h48);
            exp_q.push_back(8'h3D);
            exp_q.push_back(8'h30 + h / 8'd100);
            exp_q.push_back(8'h30 + (h / 8'd10) % 8'd10);
            exp_q.push_back(8'h30 + h % 8'd10);
            exp_q.push_back(8'h20);
            exp_q.push_back(8'h54);
            exp_q.push_back(8'h3D);
            exp_q.push_back(8'h30 + t / 8'd100);
            exp_q.push_back(8'h30 + (t / 8'd10) % 8'd10);
            exp_q.push_back(8'h30 + t % 8'd10);
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end else begin
            exp_q.push_back(8'h45);
            exp_q.push_back(8'h52);
            exp_q.push_back(8'h52);
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
    endtask

    // Entered and left at a falling edge.
    task automatic put_bit(input logic b, input logic fs);
        bit_valid   = 1'b1;
        bit_val     = b;
        frame_start = fs;
        @(negedge clk);
        bit_valid   = 1'b0;
        frame_start = 1'b0;
        if ($urandom_range(0, 7) == 0) @(negedge clk);
    endtask

    task automatic wait_idle(input bit inject);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            bit_valid   = 1'b0;
            frame_start = 1'b0;
            if (!busy1) begin
                done = 1'b1;
                break;
            end
            if (inject && $urandom_range(0, 3) == 0) begin
                bit_valid   = 1'b1;
                bit_val     = 1'($urandom);
                frame_start = 1'($urandom);
            end
            @(negedge clk);
        end
        bit_valid   = 1'b0;
        frame_start = 1'b0;
        if (!done) begin
            n_checks++;
            $display("FAIL idle_timeout: busy still 1 after 20000 cycles, expected 0");
        end
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input logic [7:0] b3, input logic [7:0] b4,
                              input bit fs_with_bit, input bit inject);
        logic [39:0] f;
        bit good;
        f    = {b0, b1, b2, b3, b4};
        good = ((int'(b0) + int'(b1) + int'(b2) + int'(b3)) % 256) == int'(b4);
        push_expected(b0, b2, good);
        if (good) begin
            model_gc = (model_gc + 1) % 256;
            exp2_count += 13;
            good_total++;
        end
        if (fs_with_bit) begin
            put_bit(f[39], 1'b1);
        end else begin
            frame_start = 1'b1;
            @(negedge clk);
            frame_start = 1'b0;
            put_bit(f[39], 1'b0);
        end
        for (int i = 38; i >= 0; i--) put_bit(f[i], 1'b0);
        if (!good) begin
            @(negedge clk);
            check("drop_busy_within_2", int'(busy2), 0);
            check("drop_csum_err", int'(cerr2), 1);
        end
        wait_idle(inject && good);
        check("csum_err", int'(cerr1), good ? 0 : 1);
        check("good_count", int'(gc1), model_gc);
        check("drop_good_count", int'(gc2), model_gc);
        check("queue_drained", exp_q.size(), 0);
        check("drop_send_count", tx2_count, exp2_count);
    endtask

    task automatic send_random(input bit good, input bit fs_with_bit, input bit inject);
        logic [7:0] r0, r1, r2, r3, r4;
        r0 = 8'($urandom);
        r1 = 8'($urandom);
        r2 = 8'($urandom);
        r3 = 8'($urandom);
        r4 = r0 + r1 + r2 + r3;
        if (!good) r4 = r4 + 8'($urandom_range(1, 255));
        send_frame(r0, r1, r2, r3, r4, fs_with_bit, inject);
    endtask

    initial begin
        int base;
        bit seen;
        logic [7:0] a0, a2, a4;

        repeat (3) @(negedge clk);
        check("rst_tx_data", int'(tx_data1), 0);
        check("rst_tx_send", int'(tx_send1), 0);
        check("rst_busy", int'(busy1), 0);
        check("rst_csum_err", int'(cerr1), 0);
        check("rst_good_count", int'(gc1), 0);
        reset_n = 1'b1;

        hold = 1042;
        send_frame(8'h2D, 8'h00, 8'h17, 8'h00, 8'h44, 1'b0, 1'b0);
        hold = 1;
        send_frame(8'h2D, 8'h00, 8'h17, 8'h00, 8'h45, 1'b0, 1'b0);

        // Abandoned partial frame followed by a complete one.
        for (int i = 0; i < 17; i++) put_bit(1'($urandom), 1'b0);
        send_random(1'b1, 1'b0, 1'b0);

        send_random(1'b1, 1'b0, 1'b1);
        send_frame(8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF, 1'b1, 1'b1);

        while (good_total < 260) begin
            send_random($urandom_range(0, 7) != 0, 1'($urandom), 1'($urandom));
        end

        // Reset in the middle of the fifth character.
        hold = 8;
        base = tx1_count;
        a0 = 8'($urandom);
        a2 = 8'($urandom);
        a4 = a0 + a2;
        push_expected(a0, a2, 1'b1);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        for (int i = 39; i >= 0; i--) put_bit(({a0, 8'h00, a2, 8'h00, a4} >> i) & 40'd1, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (tx1_count >= base + 5) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) begin
            n_checks++;
            $display("FAIL fifth_char_timeout: sends=%0d, expected %0d", tx1_count - base, 5);
        end
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_tx_data", int'(tx_data1), 0);
        check("midrst_tx_send", int'(tx_send1), 0);
        check("midrst_busy", int'(busy1), 0);
        check("midrst_good_count", int'(gc1), 0);
        check("midrst_drop_busy", int'(busy2), 0);
        exp_q.delete();
        model_gc = 0;
        exp2_count += 5;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        send_random(1'b1, 1'b1, 1'b0);
        check("sends_after_reset_frame", tx1_count - base, 5 + 13);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
